alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 16, datapath width in bits; SHALL be even and >= 4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request; sampled only when busy=0.
REQ-005 opc  input  3  operation select, sampled with start.
REQ-006 A  input  WIDTH  operand A, sampled with start.
REQ-007 B  input  WIDTH  operand B, sampled with start.
REQ-008 w  output  WIDTH  registered result.
REQ-009 neg  output  1  registered; equals w[WIDTH-1].
REQ-010 zer  output  1  registered; 1 when w == 0.
REQ-011 cry  output  1  registered carry / no-borrow / high-product flag.
REQ-012 ovf  output  1  registered signed-overflow flag.
REQ-013 busy  output  1  high while a multi-cycle operation is in progress.
REQ-014 done  output  1  one-cycle pulse; w and flags are new in that cycle.

Function
REQ-015 Opcodes: 000 NEG (~A+1); 001 INC (A+1); 010 ADD (A+B); 011 SUB (A-B); 100 AND; 101 OR; 110 PACK {A[WIDTH/2-1:0], B[WIDTH/2-1:0]}; 111 MUL (low WIDTH bits of unsigned A*B).
REQ-016 All arithmetic SHALL be WIDTH bits, wrapping modulo 2^WIDTH; carry taken from bit WIDTH of the (WIDTH+1)-bit sum.
REQ-017 FSM states: IDLE, MUL; no other states.
REQ-018 IDLE, start=1, opc != 111: result and flags registered at that edge; done=1 for the following cycle; state stays IDLE; latency 1.
REQ-019 IDLE, start=1, opc = 111: A, B captured, accumulator and step counter cleared, busy=1 from the next cycle, state -> MUL.
REQ-020 MUL: one shift-add step per edge (LSB of B-copy selects adding the shifted A-copy); after exactly WIDTH steps, w/flags registered, done=1 for one cycle, busy=0, state -> IDLE; total latency WIDTH+1 edges.
REQ-021 start while busy=1 SHALL be ignored; no queuing.
REQ-022 start in the done cycle (busy=0) SHALL be accepted; back-to-back single-cycle ops give done every cycle.
REQ-023 w and all flags SHALL hold their values until the next completion; done=0 otherwise.
REQ-024 cry: NEG/INC/ADD carry-out; SUB 1 when A >= B unsigned; MUL 1 when the upper WIDTH product bits are non-zero; AND/OR/PACK 0.
REQ-025 ovf: ADD when A, B same sign and w differs; SUB when A, B differ in sign and w sign differs from A; INC when A = 0111..1; NEG when A = 1000..0; all other ops 0.
REQ-026 NEG of 0 SHALL give w=0, zer=1, cry=1, ovf=0.

Reset
REQ-027 rst=1 at an edge SHALL force state IDLE, w=0, neg=0, zer=0, cry=0, ovf=0, busy=0, done=0, counter and accumulator cleared.
REQ-028 rst SHALL take priority over start and over an in-progress MUL; an aborted MUL produces no done.
REQ-029 zer SHALL be 0 after reset even though w=0.

Verification (WIDTH=16)
REQ-030 ADD A=16'h7FFF, B=16'h0001 -> next cycle done=1, w=16'h8000, neg=1, ovf=1, cry=0, zer=0.
REQ-031 SUB A=16'h0003, B=16'h0005 -> w=16'hFFFE, cry=0, neg=1; SUB A=5, B=3 -> w=2, cry=1.
REQ-032 MUL A=16'h0100, B=16'h0100 -> busy for 16 cycles, done on the 17th cycle after start, w=0, zer=1, cry=1; start pulses during busy ignored.
REQ-033 NEG A=16'h8000 -> w=16'h8000, ovf=1; PACK A=16'h12AB, B=16'h34CD -> w=16'hABCD.
REQ-034 MUL A=3, B=5 started, rst=1 at step 8 -> all outputs 0, no done; new ADD A=1, B=1 accepted next cycle -> w=2.
REQ-035 Back-to-back: INC A=16'hFFFF then AND A=16'hF0F0, B=16'h0FF0 on consecutive cycles -> done two cycles running; w=0 (zer=1, cry=1) then w=16'h00F0 (cry=0).

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if -- request/result bundle for the sequential ALU.
//   master : drives start, opc, A, B; observes w, flags, busy, done
//   slave  : the ALU itself
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [2:0]       opc;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] w;
    logic             neg;
    logic             zer;
    logic             cry;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, opc, A, B,
        input  w, neg, zer, cry, ovf, busy, done
    );

    modport slave (
        input  start, opc, A, B,
        output w, neg, zer, cry, ovf, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq -- ALU with single-cycle NEG/INC/ADD/SUB/AND/OR/PACK and a
// WIDTH-step shift-add multiplier.
//   clk  : sole clock, rising edge
//   rst  : synchronous, active-high
//   bus  : alu_seq_if.slave (start/opc/A/B in; w/neg/zer/cry/ovf/busy/done out)
// WIDTH must be even and >= 4 (PACK takes the low half of each operand).
//
// state  | meaning
// S_IDLE | waiting for start; single-cycle ops complete here
// S_MUL  | shift-add multiply in progress, one step per edge
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int HW = WIDTH / 2;
    localparam logic [WIDTH:0]   ONE     = 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   w_q, w_d;
    logic               neg_q, neg_d, zer_q, zer_d, cry_q, cry_d, ovf_q, ovf_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] a_q, a_d, acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   res;
    logic               c, v;
    logic [2*WIDTH-1:0] mul_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            neg_q   <= 1'b0;
            zer_q   <= 1'b0;
            cry_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            neg_q   <= neg_d;
            zer_q   <= zer_d;
            cry_q   <= cry_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Single-cycle datapath; SUB uses A + ~B + 1 so the carry is the no-borrow flag.
    always_comb begin
        sum = '0;
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (bus.opc)
            3'b000: begin
                sum = {1'b0, ~bus.A} + ONE;
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (bus.A == MIN_NEG);
            end
            3'b001: begin
                sum = {1'b0, bus.A} + ONE;
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (bus.A == MAX_POS);
            end
            3'b010: begin
                sum = {1'b0, bus.A} + {1'b0, bus.B};
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (res[WIDTH-1] != bus.A[WIDTH-1]);
            end
            3'b011: begin
                sum = {1'b0, bus.A} + {1'b0, ~bus.B} + ONE;
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (res[WIDTH-1] != bus.A[WIDTH-1]);
            end
            3'b100:  res = bus.A & bus.B;
            3'b101:  res = bus.A | bus.B;
            3'b110:  res = {bus.A[HW-1:0], bus.B[HW-1:0]};
            default: res = '0;
        endcase
    end

    assign mul_acc = acc_q + (b_q[0] ? a_q : '0);

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        neg_d   = neg_q;
        zer_d   = zer_q;
        cry_d   = cry_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.opc == 3'b111) begin
                        a_d     = {{WIDTH{1'b0}}, bus.A};
                        b_d     = bus.B;
                        acc_d   = '0;
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = S_MUL;
                    end else begin
                        w_d    = res;
                        neg_d  = res[WIDTH-1];
                        zer_d  = (res == '0);
                        cry_d  = c;
                        ovf_d  = v;
                        done_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_acc;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q - 1'b1;
                // cnt_q == 0 marks the WIDTH-th step.
                if (cnt_q == '0) begin
                    w_d     = mul_acc[WIDTH-1:0];
                    neg_d   = mul_acc[WIDTH-1];
                    zer_d   = (mul_acc[WIDTH-1:0] == '0);
                    cry_d   = |mul_acc[2*WIDTH-1:WIDTH];
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.w    = w_q;
    assign bus.neg  = neg_q;
    assign bus.zer  = zer_q;
    assign bus.cry  = cry_q;
    assign bus.ovf  = ovf_q;
    assign bus.done = done_q;
    assign bus.busy = (state_q == S_MUL);
endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: integer arithmetic on the operand values.
    function automatic void ref_op(input logic [2:0] op, input longint a, input longint b,
                                   output longint w, output bit c, output bit v);
        longint m, half, sa, sb, r, p;
        m    = 64'd1 << W;
        half = 64'd1 << (W - 1);
        sa   = (a >= half) ? a - m : a;
        sb   = (b >= half) ? b - m : b;
        c = 0; v = 0; w = 0;
        case (op)
            3'd0: begin w = (m - a) % m; c = (a == 0); r = -sa; v = (r > half - 1); end
            3'd1: begin w = (a + 1) % m; c = (a + 1 >= m); r = sa + 1; v = (r > half - 1); end
            3'd2: begin w = (a + b) % m; c = (a + b >= m); r = sa + sb; v = (r > half - 1) || (r < -half); end
            3'd3: begin w = (a - b + m) % m; c = (a >= b); r = sa - sb; v = (r > half - 1) || (r < -half); end
            3'd4: w = a & b;
            3'd5: w = a | b;
            3'd6: w = (a % (64'd1 << (W/2))) * (64'd1 << (W/2)) + b % (64'd1 << (W/2));
            default: begin p = a * b; w = p % m; c = (p >= m); end
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit junk);
        longint ew;
        bit     ec, ev, got;
        int     lat, busy_cyc;
        ref_op(op, longint'(a), longint'(b), ew, ec, ev);
        @(negedge clk);
        bus.start = 1'b1; bus.opc = op; bus.A = a; bus.B = b;
        @(posedge clk);
        lat = 0; busy_cyc = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (bus.done) got = 1;
            if (bus.busy) begin
                busy_cyc++;
                if (junk) begin
                    bus.start = 1'($urandom); bus.opc = 3'($urandom);
                    bus.A = W'($urandom); bus.B = W'($urandom);
                end else bus.start = 1'b0;
            end else bus.start = 1'b0;
        end
        chk("done_seen", 64'(got), 64'd1);
        chk("latency", 64'(lat), (op == 3'd7) ? 64'd17 : 64'd1);
        if (op == 3'd7) chk("busy_cycles", 64'(busy_cyc), 64'd16);
        chk("w", 64'(bus.w), 64'(ew));
        chk("flags", {60'd0, bus.neg, bus.zer, bus.cry, bus.ovf},
            {60'd0, ew[W-1], (ew == 0), ec, ev});
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return 16'h8000;
            3: return 16'h7FFF;
            4: return W'($urandom_range(0, 3));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.opc = '0; bus.A = '0; bus.B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {bus.w, bus.neg, bus.zer, bus.cry, bus.ovf, bus.busy, bus.done}, 64'd0);
        // start while in reset must not complete
        bus.start = 1'b1; bus.opc = 3'd2; bus.A = 16'd1; bus.B = 16'd1;
        @(negedge clk);
        chk("rst_prio", {bus.w, bus.done, bus.busy}, 64'd0);
        bus.start = 1'b0;
        rst = 1'b0;

        run_op(3'd2, 16'h7FFF, 16'h0001, 0);
        chk("add_ovf", {bus.w, bus.neg, bus.ovf, bus.cry, bus.zer}, {16'h8000, 4'b1100});
        run_op(3'd3, 16'h0003, 16'h0005, 0);
        chk("sub_borrow", {bus.w, bus.cry, bus.neg}, {16'hFFFE, 2'b01});
        run_op(3'd3, 16'h0005, 16'h0003, 0);
        chk("sub_noborrow", {bus.w, bus.cry}, {16'h0002, 1'b1});
        run_op(3'd7, 16'h0100, 16'h0100, 1);
        chk("mul_hi", {bus.w, bus.zer, bus.cry}, {16'h0000, 2'b11});
        run_op(3'd0, 16'h8000, 16'h0000, 0);
        chk("neg_min", {bus.w, bus.ovf}, {16'h8000, 1'b1});
        run_op(3'd0, 16'h0000, 16'h0000, 0);
        chk("neg_zero", {bus.w, bus.zer, bus.cry, bus.ovf}, {16'h0000, 3'b110});
        run_op(3'd6, 16'h12AB, 16'h34CD, 0);
        chk("pack", 64'(bus.w), 64'h0000ABCD);

        // reset in the middle of a multiply
        @(negedge clk);
        bus.start = 1'b1; bus.opc = 3'd7; bus.A = 16'd3; bus.B = 16'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mul_abort", {bus.w, bus.neg, bus.zer, bus.cry, bus.ovf, bus.busy, bus.done}, 64'd0);
        rst = 1'b0;
        bus.start = 1'b1; bus.opc = 3'd2; bus.A = 16'd1; bus.B = 16'd1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("post_abort_add", {bus.done, bus.w}, {1'b1, 16'd2});

        // back-to-back single-cycle ops
        bus.start = 1'b1; bus.opc = 3'd1; bus.A = 16'hFFFF; bus.B = 16'h0;
        @(negedge clk);
        bus.opc = 3'd4; bus.A = 16'hF0F0; bus.B = 16'h0FF0;
        chk("b2b_inc", {bus.done, bus.w, bus.zer, bus.cry}, {1'b1, 16'h0000, 2'b11});
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_and", {bus.done, bus.w, bus.cry}, {1'b1, 16'h00F0, 1'b0});
        @(negedge clk);
        chk("hold", {bus.done, bus.w, bus.cry}, {1'b0, 16'h00F0, 1'b0});

        for (int i = 0; i < 150; i++)
            run_op(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
